// File: rtl/axi4_sram_slave_if.sv
// axi4_if: AXI4 bus bundle carrying the channels used by the on-chip SRAM slave.
interface axi4_if #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 4
);
  logic [AXI4_ID_WIDTH-1:0]      awid;
  logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awvalid;
  logic                          awready;

  logic [AXI4_DATA_WIDTH-1:0]    wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]  wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;

  logic [AXI4_ID_WIDTH-1:0]      bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  logic [AXI4_ID_WIDTH-1:0]      arid;
  logic [AXI4_ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arvalid;
  logic                          arready;

  logic [AXI4_ID_WIDTH-1:0]      rid;
  logic [AXI4_DATA_WIDTH-1:0]    rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: single-transaction AXI4 slave in front of a single-cycle SRAM.
// Define AXI4_SRAM_SLAVE_WRAP_EN to support WRAP bursts; otherwise WRAP bursts
// are treated as unsupported (SLVERR on every beat, writes suppressed).
module axi4_sram_slave #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 4,
  parameter int unsigned MEM_WORDS          = 4096
) (
  input logic   clk_i,
  input logic   rst_i,
  axi4_if.slave s
);

  localparam int unsigned AW = AXI4_ADDRESS_WIDTH;
  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam longint unsigned MemBytes = 64'(MEM_WORDS) * 64'd4;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

`ifdef AXI4_SRAM_SLAVE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWdata, StWresp, StRdata} state_e;

  state_e                   state_q, state_d;
  logic                     rd_prio_q, rd_prio_d;  // 1: read wins the next tie
  logic [AXI4_ID_WIDTH-1:0] id_q, id_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [7:0]               len_q, len_d;
  logic [2:0]               size_q, size_d;
  logic [1:0]               burst_q, burst_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     unsup_q, unsup_d;

  logic [31:0]              mem [MEM_WORDS];
  logic [31:0]              ram_q;
  logic [IdxW-1:0]          rd_idx;
  logic [IdxW-1:0]          wr_idx;
  logic                     mem_we;
  logic                     in_range;
  logic                     beat_err;
  logic [AW-1:0]            addr_nxt;

  function automatic logic is_unsup(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = WrapEn && (len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (size > 3'd2) || (burst == 2'b11) || ((burst == BurstWrap) && !wrap_ok);
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] step, mask, inc;
    step = AW'(1) << size;
    inc  = addr + step;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      BurstFixed: return addr;
      BurstWrap:  return (addr & ~mask) | (inc & mask);
      default:    return inc;  // INCR: no wrap at the memory top, overflow beats error out
    endcase
  endfunction

  assign in_range = 64'(addr_q) < MemBytes;
  assign beat_err = !in_range || unsup_q;
  assign addr_nxt = next_addr(addr_q, len_q, size_q, burst_q);
  assign wr_idx   = addr_q[IdxW+1:2];

  logic unused_wlast;
  assign unused_wlast = s.wlast;

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rd_prio_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      unsup_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      unsup_q   <= unsup_d;
    end
  end

  // SRAM: byte-lane writes, registered read of the prefetch index.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s.wstrb[i]) mem[wr_idx][8*i +: 8] <= s.wdata[8*i +: 8];
      end
    end
    ram_q <= mem[rd_idx];
  end

  // Read index: the beat that will be on the bus next cycle.
  always_comb begin
    rd_idx = addr_q[IdxW+1:2];
    if (state_q == StIdle) begin
      rd_idx = s.araddr[IdxW+1:2];
    end else if (state_q == StRdata && s.rready) begin
      rd_idx = addr_nxt[IdxW+1:2];
    end
  end

  // FSM next state, arbitration and channel outputs; everything low in reset.
  always_comb begin
    state_d   = state_q;
    rd_prio_d = rd_prio_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unsup_d   = unsup_q;
    mem_we    = 1'b0;
    s.awready = 1'b0;
    s.arready = 1'b0;
    s.wready  = 1'b0;
    s.bvalid  = 1'b0;
    s.bid     = '0;
    s.bresp   = RespOkay;
    s.rvalid  = 1'b0;
    s.rid     = '0;
    s.rdata   = '0;
    s.rresp   = RespOkay;
    s.rlast   = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          s.awready = s.awvalid && !(s.arvalid && rd_prio_q);
          s.arready = s.arvalid && !s.awready;
          if (s.awready) begin
            id_d      = s.awid;
            addr_d    = s.awaddr;
            len_d     = s.awlen;
            size_d    = s.awsize;
            burst_d   = s.awburst;
            unsup_d   = is_unsup(s.awlen, s.awsize, s.awburst);
            cnt_d     = '0;
            err_d     = 1'b0;
            rd_prio_d = 1'b1;
            state_d   = StWdata;
          end else if (s.arready) begin
            id_d      = s.arid;
            addr_d    = s.araddr;
            len_d     = s.arlen;
            size_d    = s.arsize;
            burst_d   = s.arburst;
            unsup_d   = is_unsup(s.arlen, s.arsize, s.arburst);
            cnt_d     = '0;
            err_d     = 1'b0;
            rd_prio_d = 1'b0;
            state_d   = StRdata;
          end
        end
        StWdata: begin
          s.wready = 1'b1;
          if (s.wvalid) begin
            mem_we = !beat_err;
            err_d  = err_q || beat_err;
            addr_d = addr_nxt;
            cnt_d  = cnt_q + 8'd1;
            // Beat count alone ends the burst; WLAST is not trusted.
            if (cnt_q == len_q) state_d = StWresp;
          end
        end
        StWresp: begin
          s.bvalid = 1'b1;
          s.bid    = id_q;
          s.bresp  = err_q ? RespSlvErr : RespOkay;
          if (s.bready) state_d = StIdle;
        end
        StRdata: begin
          s.rvalid = 1'b1;
          s.rid    = id_q;
          s.rdata  = beat_err ? '0 : ram_q;
          s.rresp  = beat_err ? RespSlvErr : RespOkay;
          s.rlast  = (cnt_q == len_q);
          if (s.rready) begin
            addr_d = addr_nxt;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == len_q) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: directed bench with a byte-level memory model and a
// per-cycle compare process on the R and B channels.
module tb_axi4_sram_slave;

  localparam int unsigned MemWords = 256;
  localparam longint unsigned MemBytes = 64'(MemWords) * 64'd4;

`ifdef AXI4_SRAM_SLAVE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rbeat_t      rexp[$];
  bexp_t       bexp[$];
  logic [7:0]  mmem [longint unsigned];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [3:0]  got_id[$];
  int          r_cycles;
  int          ar_wait;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  axi4_if #(
    .AXI4_ADDRESS_WIDTH(32),
    .AXI4_DATA_WIDTH   (32),
    .AXI4_ID_WIDTH     (4)
  ) bus ();

  axi4_sram_slave #(
    .AXI4_ADDRESS_WIDTH(32),
    .AXI4_DATA_WIDTH   (32),
    .AXI4_ID_WIDTH     (4),
    .MEM_WORDS         (MemWords)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .s    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic bit unsup(input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    bit wrap_ok;
    wrap_ok = WrapEn && (len == 1 || len == 3 || len == 7 || len == 15);
    return size > 2 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok);
  endfunction

  function automatic longint unsigned beat_addr(input longint unsigned a, input int i,
                                                input logic [7:0] len, input logic [2:0] size,
                                                input logic [1:0] burst);
    longint unsigned step = 64'd1 << size;
    longint unsigned total = (64'(len) + 1) * step;
    longint unsigned base;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      base = a - (a % total);
      return base + ((a - base) + 64'(i) * step) % total;
    end
    return a + 64'(i) * step;
  endfunction

  task automatic model_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit u = unsup(len, size, burst);
    bit err = u;
    bexp_t b;
    for (int i = 0; i <= int'(len); i++) begin
      longint unsigned ba = beat_addr(64'(a), i, len, size, burst);
      if (ba >= MemBytes) err = 1;
      else if (!u) begin
        for (int l = 0; l < 4; l++) begin
          if (sbuf[i][l]) mmem[(ba & ~64'd3) + 64'(l)] = wbuf[i][8*l +: 8];
        end
      end
    end
    b.id = id;
    b.resp = err ? 2'b10 : 2'b00;
    bexp.push_back(b);
  endtask

  task automatic model_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    bit u = unsup(len, size, burst);
    rbeat_t r;
    for (int i = 0; i <= int'(len); i++) begin
      longint unsigned ba = beat_addr(64'(a), i, len, size, burst);
      bit bad = u || (ba >= MemBytes);
      r.data = '0;
      if (!bad) begin
        for (int l = 0; l < 4; l++) r.data[8*l +: 8] = mmem[(ba & ~64'd3) + 64'(l)];
      end
      r.resp = bad ? 2'b10 : 2'b00;
      r.last = (i == int'(len));
      r.id = id;
      rexp.push_back(r);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid) begin
        if (rexp.size() == 0) begin
          check("r_unexpected_rvalid", 32'(bus.rvalid), 32'd0);
        end else begin
          check("rdata", bus.rdata, rexp[0].data);
          check("rresp", 32'(bus.rresp), 32'(rexp[0].resp));
          check("rlast", 32'(bus.rlast), 32'(rexp[0].last));
          check("rid", 32'(bus.rid), 32'(rexp[0].id));
          if (bus.rready) void'(rexp.pop_front());
        end
      end
      if (bus.bvalid) begin
        if (bexp.size() == 0) begin
          check("b_unexpected_bvalid", 32'(bus.bvalid), 32'd0);
        end else begin
          check("bresp", 32'(bus.bresp), 32'(bexp[0].resp));
          check("bid", 32'(bus.bid), 32'(bexp[0].id));
          if (bus.bready) void'(bexp.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int g = 0;
    bus.awvalid = 1'b1;
    bus.awid = id;
    bus.awaddr = a;
    bus.awlen = len;
    bus.awsize = size;
    bus.awburst = burst;
    @(negedge clk);
    while (!bus.awready && g < 50) begin
      tick();
      @(negedge clk);
      g++;
    end
    check("aw_accept", 32'(bus.awready), 32'd1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      int g = 0;
      bus.wvalid = 1'b1;
      bus.wdata = wbuf[i];
      bus.wstrb = sbuf[i];
      bus.wlast = (i == int'(len));
      @(negedge clk);
      if (i == 0) check("wready_first_beat", 32'(bus.wready), 32'd1);
      while (!bus.wready && g < 50) begin
        tick();
        @(negedge clk);
        g++;
      end
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
  endtask

  task automatic b_wait();
    int g = 0;
    bus.bready = 1'b1;
    @(negedge clk);
    check("bvalid_latency", 32'(bus.bvalid), 32'd1);
    while (!bus.bvalid && g < 50) begin
      tick();
      @(negedge clk);
      g++;
    end
    b_id = bus.bid;
    b_resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int g = 0;
    bus.arvalid = 1'b1;
    bus.arid = id;
    bus.araddr = a;
    bus.arlen = len;
    bus.arsize = size;
    bus.arburst = burst;
    @(negedge clk);
    while (!bus.arready && g < 50) begin
      tick();
      @(negedge clk);
      g++;
    end
    ar_wait = g;
    check("ar_accept", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  // Collects beats; toggle=1 stalls every other cycle.
  task automatic r_collect(input logic [7:0] len, input bit toggle);
    int n = 0;
    int g = 0;
    got_data.delete();
    got_resp.delete();
    got_last.delete();
    got_id.delete();
    while (n <= int'(len) && g < 200) begin
      bus.rready = toggle ? g[0] : 1'b1;
      @(negedge clk);
      if (g == 0) check("rvalid_latency", 32'(bus.rvalid), 32'd1);
      if (bus.rvalid && bus.rready) begin
        got_data.push_back(bus.rdata);
        got_resp.push_back(bus.rresp);
        got_last.push_back(bus.rlast);
        got_id.push_back(bus.rid);
        n++;
      end
      tick();
      g++;
    end
    bus.rready = 1'b0;
    r_cycles = g;
    check("r_beat_count", 32'(n), 32'(len) + 1);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    model_write(id, a, len, size, burst);
    aw_hs(id, a, len, size, burst);
    w_beats(len);
    b_wait();
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    model_read(id, a, len, size, burst);
    ar_hs(id, a, len, size, burst);
    r_collect(len, toggle);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.wlast} = '0;
    {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst} = '0;
    {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst} = '0;
    bus.wdata = '0;
    bus.wstrb = '0;

    // Both address channels valid from reset: write must win.
    wbuf[0] = 32'hCAFEF00D;
    sbuf[0] = 4'hF;
    bus.awvalid = 1'b1; bus.awid = 4'd5; bus.awaddr = 32'h80;
    bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.arvalid = 1'b1; bus.arid = 4'd6; bus.araddr = 32'h80;
    bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    model_write(4'd5, 32'h80, 8'd0, 3'd2, 2'b01);
    model_read(4'd6, 32'h80, 8'd0, 3'd2, 2'b01);
    repeat (3) tick();
    @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("arb_awready_first", 32'(bus.awready), 32'd1);
    check("arb_arready_first", 32'(bus.arready), 32'd0);
    tick();
    bus.awvalid = 1'b0;
    @(negedge clk);
    check("arb_arready_busy", 32'(bus.arready), 32'd0);
    tick();
    w_beats(8'd0);
    b_wait();
    check("arb_bid", 32'(b_id), 32'd5);
    g = 0;
    @(negedge clk);
    while (!bus.arready && g < 50) begin
      tick();
      @(negedge clk);
      g++;
    end
    check("arb_ar_accept", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    r_collect(8'd0, 1'b0);
    check("arb_rdata", got_data[0], 32'hCAFEF00D);

    // Single write then read, with a tie that the read must win after a write.
    wbuf[0] = 32'hDEADBEEF;
    sbuf[0] = 4'hF;
    do_write(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
    check("t1_bresp", 32'(b_resp), 32'd0);
    check("t1_bid", 32'(b_id), 32'd3);
    model_read(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
    wbuf[0] = 32'h00000055;
    sbuf[0] = 4'hF;
    model_write(4'd7, 32'h104, 8'd0, 3'd2, 2'b01);
    bus.awvalid = 1'b1; bus.awid = 4'd7; bus.awaddr = 32'h104;
    bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.arvalid = 1'b1; bus.arid = 4'd3; bus.araddr = 32'h100;
    bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    @(negedge clk);
    check("arb2_arready", 32'(bus.arready), 32'd1);
    check("arb2_awready", 32'(bus.awready), 32'd0);
    tick();
    bus.arvalid = 1'b0;
    r_collect(8'd0, 1'b0);
    check("t1_rdata", got_data[0], 32'hDEADBEEF);
    check("t1_rlast", 32'(got_last[0]), 32'd1);
    check("t1_rid", 32'(got_id[0]), 32'd3);
    aw_hs(4'd7, 32'h104, 8'd0, 3'd2, 2'b01);
    w_beats(8'd0);
    b_wait();

    // Byte strobes.
    wbuf[0] = 32'h11223344;
    sbuf[0] = 4'hF;
    do_write(4'd1, 32'h20, 8'd0, 3'd2, 2'b01);
    wbuf[0] = 32'hAABBCCDD;
    sbuf[0] = 4'b0101;
    do_write(4'd1, 32'h20, 8'd0, 3'd2, 2'b01);
    do_read(4'd2, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);
    check("strb_rdata", got_data[0], 32'h11BB33DD);

    // INCR streaming, then the same burst with rready toggling.
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'(i);
      sbuf[i] = 4'hF;
    end
    do_write(4'd4, 32'h40, 8'd7, 3'd2, 2'b01);
    do_read(4'd4, 32'h40, 8'd7, 3'd2, 2'b01, 1'b0);
    check("incr_cycles", 32'(r_cycles), 32'd8);
    check("incr_beat3", got_data[3], 32'd3);
    check("incr_beat7", got_data[7], 32'd7);
    check("incr_last7", 32'(got_last[7]), 32'd1);
    check("incr_last6", 32'(got_last[6]), 32'd0);
    do_read(4'd9, 32'h40, 8'd7, 3'd2, 2'b01, 1'b1);
    check("stall_beat5", got_data[5], 32'd5);

    // WRAP read over a 16-byte window.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0 + 32'(i);
      sbuf[i] = 4'hF;
    end
    do_write(4'd2, 32'h0, 8'd3, 3'd2, 2'b01);
    do_read(4'd2, 32'h8, 8'd3, 3'd2, 2'b10, 1'b0);
`ifdef AXI4_SRAM_SLAVE_WRAP_EN
    check("wrap_beat0", got_data[0], 32'hA2);
    check("wrap_beat2", got_data[2], 32'hA0);
    check("wrap_beat3", got_data[3], 32'hA1);
`else
    check("wrap_beat0", got_data[0], 32'h0);
    check("wrap_resp1", 32'(got_resp[1]), 32'd2);
    check("wrap_last3", 32'(got_last[3]), 32'd1);
`endif

    // FIXED burst keeps hitting one word.
    wbuf[0] = 32'h111; wbuf[1] = 32'h222; wbuf[2] = 32'h333;
    sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
    do_write(4'd6, 32'h60, 8'd2, 3'd0 + 3'd2, 2'b00);
    do_read(4'd6, 32'h60, 8'd0, 3'd2, 2'b01, 1'b0);
    check("fixed_rdata", got_data[0], 32'h333);

    // Unsupported size: write suppressed, read errors out.
    wbuf[0] = 32'hBAD0BAD0;
    sbuf[0] = 4'hF;
    do_write(4'd8, 32'h70, 8'd0, 3'd3, 2'b01);
    check("unsup_bresp", 32'(b_resp), 32'd2);
    do_read(4'd8, 32'h70, 8'd0, 3'd3, 2'b01, 1'b0);
    check("unsup_rresp", 32'(got_resp[0]), 32'd2);

    // Running off the top of memory.
    wbuf[0] = 32'h12345678; wbuf[1] = 32'h9ABCDEF0;
    sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(4'd10, 32'(MemBytes - 4), 8'd1, 3'd2, 2'b01);
    check("oor_bresp", 32'(b_resp), 32'd2);
    do_read(4'd10, 32'(MemBytes - 4), 8'd1, 3'd2, 2'b01, 1'b0);
    check("oor_top_word", got_data[0], 32'h12345678);
    check("oor_beat1_resp", 32'(got_resp[1]), 32'd2);
    do_read(4'd10, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    check("oor_no_alias", got_data[0], 32'hA0);

    // Reset in the middle of a 4-beat read.
    model_read(4'd11, 32'h40, 8'd3, 3'd2, 2'b01);
    ar_hs(4'd11, 32'h40, 8'd3, 3'd2, 2'b01);
    bus.rready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    rexp.delete();
    tick();
    @(negedge clk);
    check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    bus.rready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rvalid_idle", 32'(bus.rvalid), 32'd0);
    tick();
    do_read(4'd12, 32'h44, 8'd0, 3'd2, 2'b01, 1'b0);
    check("midrst_ar_wait", 32'(ar_wait), 32'd0);
    check("midrst_rdata", got_data[0], 32'd1);

    repeat (3) tick();
    check("rexp_drained", 32'(rexp.size()), 32'd0);
    check("bexp_drained", 32'(bexp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_sram_slave.md
# axi4_sram_slave

AXI4 slave-side on-chip SRAM that terminates the `master` port of the dual-A23 core complex, giving it a local boot/working memory.
- Services one AXI4 transaction at a time, read or write, with INCR, FIXED and (optionally) WRAP bursts, byte strobes and ID echo.
- Single-cycle synchronous RAM; read bursts stream at one beat per cycle.

## Interface
Parameters:
- `AXI4_ADDRESS_WIDTH`, 32: address width of `s`.
- `AXI4_DATA_WIDTH`, 32: data width of `s`; fixed at 32, other values unsupported.
- `AXI4_ID_WIDTH`, 4: ID width of `s`.
- `MEM_WORDS`, 4096: depth in 32-bit words; power of two.

Ports:
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `s`  `axi4_if.slave`  parameterised: AXI4 slave port.

## Operation
- Byte address A is in range iff `A < MEM_WORDS*4`; word index is `A[log2(MEM_WORDS)+1:2]`.
- FSM states:
  - IDLE: `awready`/`arready` offered per arbitration.
    - AW handshake: latch AWID, AWADDR, AWLEN, AWBURST, AWSIZE; go to WDATA.
    - AR handshake: latch the corresponding AR fields; go to RDATA.
  - WDATA: `wready=1`.
    - Each W handshake writes the lanes with `wstrb[i]=1` at the current address, if in range.
    - Address then advances; beat counter increments.
    - After beat LEN+1, go to WRESP.
    - WLAST is ignored for termination.
  - WRESP: `bvalid=1`, `bid`=latched ID.
    - `bresp`=SLVERR(2'b10) if any beat was out of range or unsupported, else OKAY.
    - On `bready`, go to IDLE.
  - RDATA: `rvalid` from the cycle after AR accept.
    - `rdata`=memory word, or 0 when out of range.
    - Per-beat `rresp`: OKAY, or SLVERR when out of range or unsupported.
    - `rid`=latched ID; `rlast=1` on beat LEN+1.
    - After the last-beat handshake, go to IDLE.
- Arbitration in IDLE:
  - Only one of `awready`/`arready` is high in a cycle.
  - Both valid: serve the class not served last; the priority flag resets to "write first".
  - Only one valid: serve it.
- Address update, step = `1<<AxSIZE`:
  - FIXED: unchanged.
  - INCR: add step. Overflow past memory top yields SLVERR beats; the address is not wrapped.
  - WRAP: add step within a `(LEN+1)*step` aligned window. LEN must be 1, 3, 7 or 15; any other LEN is unsupported (all beats SLVERR).
- Unsupported: AxSIZE>2 or AxBURST=2'b11. Every beat of such a burst gets SLVERR; writes are suppressed.
- Reset:
  - All outputs low; FSM to IDLE; priority flag to "write first".
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst with no response.

## Timing
- AW/AR acceptance: earliest on the cycle the valid is seen in IDLE (`ready` is combinational from valid and priority).
- Write: first W beat accepted the cycle after the AW handshake. `bvalid` rises the cycle after the last W handshake. Next AW can be accepted the cycle after the B handshake.
- Read:
  - First `rvalid` is one cycle after the AR handshake.
  - RAM read address is the next beat's address on a handshake, else the current one. This gives back-to-back beats with `rready` held high.
  - `rdata`/`rresp`/`rlast` are stable while `rvalid && !rready`.
  - Next AR can be accepted the cycle after the last R handshake.
- Read after write to the same address in consecutive transactions returns the new data.

## Configuration
- `AXI4_SRAM_SLAVE_WRAP_EN`:
  - Defined: WRAP bursts operate as above.
  - Undefined: AxBURST=WRAP is unsupported. Writes are suppressed and return BRESP=SLVERR; reads return SLVERR and 0 on every beat, with correct beat count and `rlast`.

## Test plan
- Single write then read: AW 0x100, LEN=0, W 0xDEADBEEF, strb 4'hF, id 3 -> BRESP OKAY, BID 3. AR 0x100 -> RDATA 0xDEADBEEF, RLAST=1, RID 3, rvalid one cycle after AR.
- Strobes: write 0x11223344 to 0x20, then 0xAABBCCDD with strb 4'b0101 -> read returns 0x11BB33DD.
- INCR streaming: write 8 beats 0..7 at 0x40, then read LEN=7 with `rready` held high -> data 0..7 on 8 consecutive cycles, RLAST on the 8th. Repeat with `rready` toggling -> data held stable while stalled.
- WRAP (macro defined): write 0xA0..0xA3 to 0x00..0x0C, then WRAP read LEN=3 at 0x08 -> 0xA2,0xA3,0xA0,0xA1. Same with macro undefined -> 4 beats, all SLVERR, data 0.
- Out of range: INCR write LEN=1 at `MEM_WORDS*4-4` -> BRESP SLVERR; word at `MEM_WORDS*4-4` written, no aliasing at address 0.
- Arbitration and reset:
  - AWVALID and ARVALID both high from reset -> write served first, then read.
  - Assert `rst_i` in the middle of a 4-beat read -> rvalid low the next cycle; FSM in IDLE; a new AR is accepted after reset deasserts.
